tcp_rt_event_table: RTL and testbench
=====================================

Name: tcp_rt_event_table

Overview:
Per-flow TCP retransmission event generator, parametrised in flow count, timeout and duplicate-ACK threshold. Holds a retransmit timer and a duplicate-ACK counter per flow. A round-robin scanner reports timeout and fast-retransmit events to the TX engine over a valid/ready interface. Sits between the RX ACK-processing pipeline and the TX retransmit scheduler.

Parameters:
NUM_FLOWS, 4, number of tracked flows (>=2, need not be a power of two)
FLOWID_W, $clog2(NUM_FLOWS), flow id width
TIMEOUT_CYCLES, 1250000000, retransmit timeout in clk cycles; must be < 2^(TIMESTAMP_W-1)
DUP_ACK_THRESH, 3, duplicate ACKs that trigger a fast retransmit (1..2^DUP_ACK_CNT_W-1)
ACK_W, `ACK_NUM_W, ACK number width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
arm_val  in  1  (re)arm timer for arm_flowid; always accepted
arm_flowid  in  FLOWID_W  flow to arm
disarm_val  in  1  disarm timer and clear pending events for disarm_flowid; always accepted
disarm_flowid  in  FLOWID_W  flow to disarm
ack_val  in  1  ACK observed; always accepted
ack_flowid  in  FLOWID_W  flow of ACK
ack_num  in  ACK_W  ACK number carried
evt_val  out  1  event valid
evt_flowid  out  FLOWID_W  flow of event
evt_type  out  1  0 = timeout, 1 = fast retransmit
evt_rdy  in  1  consumer accepts event

Behaviour:
- Reset: all armed, fast-rt pending and deadline bits = 0; last_ack = 0; dup_cnt = 0; scan pointer = 0; free-running now counter (TIMESTAMP_W) = 0; evt_val = 0, evt_flowid = 0, evt_type = 0. Reset asserted mid-operation drops any held event.
- now increments every cycle and wraps. Expiry test: armed and MSB of (now - deadline) == 0, i.e. wrap-safe signed compare.
- Arm: deadline <= now + TIMEOUT_CYCLES; armed <= 1; pending timeout cleared. Visible next cycle.
- Disarm: armed <= 0; fast-rt pending <= 0. If arm and disarm target the same flow in the same cycle, arm wins.
- ACK, same flow: if ack_num == last_ack, dup_cnt increments, saturating at all-ones. When the increment makes dup_cnt == DUP_ACK_THRESH, set fast-rt pending. If ack_num != last_ack, last_ack <= ack_num and dup_cnt <= 0. Ignored for flow ids >= NUM_FLOWS, as are arm and disarm.
- Scanner, two states:
  - SCAN: each cycle, inspect flow[ptr].
    - If fast-rt pending: load event (type 1), clear pending, go to HOLD.
    - Else if expired: load event (type 0), armed <= 0, go to HOLD.
    - Otherwise ptr advances, wrapping NUM_FLOWS-1 -> 0.
    - Fast-rt takes priority. A timeout on the same flow is reported on the next visit.
  - HOLD: evt_val = 1, outputs stable. On evt_rdy, return to SCAN with ptr+1. The scanner does not advance while in HOLD.
- Collisions with arm/disarm in the load cycle:
  - Arm of the scanned flow in the load cycle suppresses a timeout load; the arm takes effect.
  - Disarm in the load cycle suppresses both event types.
  - An event already in HOLD is never retracted.
- Latency: event presented <= NUM_FLOWS cycles after the condition arises with evt_rdy held high.

Decomposition:
- Add to tcp_pkg: rt_evt_e enum (RT_EVT_TIMEOUT = 0, RT_EVT_FAST = 1).
- Add to tcp_pkg: rt_flow_state_struct {deadline[TIMESTAMP_W], armed, fast_pending, last_ack[ACK_W], dup_cnt[DUP_ACK_CNT_W]}.
- Add to tcp_pkg: rt_evt_struct {flowid, evt_type}.
- Reuse TIMESTAMP_W, DUP_ACK_CNT_W and RT_TIMEOUT_CYCLES from tcp_pkg.
- Single module. State is held as flop arrays, since the scan needs a random-access read plus parallel writes. No sub-module.

Test Plan:
- NUM_FLOWS=4, TIMEOUT_CYCLES=100, evt_rdy=1. Arm flow 2 at cycle 10 -> one evt (flowid 2, type 0) between cycles 110 and 114; flow 2 disarmed afterwards; no further events.
- Re-arm flow 1 every 50 cycles for 1000 cycles -> no events. Stop re-arming -> timeout event ~100 cycles after the last arm.
- Flow 0: ACKs 500,500,500,500 -> exactly one type-1 event after the fourth ACK (third duplicate). A fifth 500 -> none. Then ACK 600 then 600 x3 -> second type-1 event.
- Arm flows 0..3 at the same cycle, evt_rdy low for 300 cycles -> evt_val held with flowid 0 stable. Release evt_rdy -> flowids 0,1,2,3 in order, one per handshake.
- Arm flow 3; at the exact expiry-load cycle, drive arm_val for flow 3 -> no event, new deadline +100. Repeat with disarm_val -> no event ever.
- Force now near 2^64-50 via a bench hook and arm with TIMEOUT=100 -> expiry ~100 cycles later despite wrap. Assert rst_n low while in HOLD -> evt_val drops immediately, all timers idle after release.

Source files
------------

// File: rtl/tcp_pkg.sv
// Shared TCP offload types and widths used by the retransmit event table
// and its neighbours in the RX/TX pipelines.
`ifndef ACK_NUM_W
`define ACK_NUM_W 32
`endif

package tcp_pkg;

    localparam int unsigned TIMESTAMP_W       = 64;
    localparam int unsigned DUP_ACK_CNT_W     = 4;
    localparam int unsigned RT_TIMEOUT_CYCLES = 1250000000;
    localparam int unsigned ACK_NUM_W         = `ACK_NUM_W;
    localparam int unsigned RT_FLOWID_W       = 8;

    typedef enum logic {
        RT_EVT_TIMEOUT = 1'b0,
        RT_EVT_FAST    = 1'b1
    } rt_evt_e;

    typedef struct packed {
        logic [TIMESTAMP_W-1:0]   deadline;
        logic                     armed;
        logic                     fast_pending;
        logic [ACK_NUM_W-1:0]     last_ack;
        logic [DUP_ACK_CNT_W-1:0] dup_cnt;
    } rt_flow_state_t;

    typedef struct packed {
        logic [RT_FLOWID_W-1:0] flowid;
        rt_evt_e                evt_type;
    } rt_evt_t;

endpackage

// File: rtl/tcp_rt_event_table.sv
// Per-flow retransmit timers and duplicate-ACK counters with a round-robin
// scanner that hands timeout / fast-retransmit events to the TX scheduler.
module tcp_rt_event_table
    import tcp_pkg::*;
#(
    parameter int unsigned NUM_FLOWS      = 4,
    parameter int unsigned FLOWID_W       = $clog2(NUM_FLOWS),
    parameter int unsigned TIMEOUT_CYCLES = RT_TIMEOUT_CYCLES,
    parameter int unsigned DUP_ACK_THRESH = 3,
    parameter int unsigned ACK_W          = `ACK_NUM_W,
    parameter logic [TIMESTAMP_W-1:0] NOW_RST_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm_val,
    input  logic [FLOWID_W-1:0] arm_flowid,
    input  logic                disarm_val,
    input  logic [FLOWID_W-1:0] disarm_flowid,
    input  logic                ack_val,
    input  logic [FLOWID_W-1:0] ack_flowid,
    input  logic [ACK_W-1:0]    ack_num,
    output logic                evt_val,
    output logic [FLOWID_W-1:0] evt_flowid,
    output logic                evt_type,
    input  logic                evt_rdy
);

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_HOLD = 1'b1
    } scan_state_e;

    scan_state_e                state_q, state_d;
    logic [FLOWID_W-1:0]        ptr_q, ptr_d, ptr_inc;
    logic [TIMESTAMP_W-1:0]     now_q;
    logic [TIMESTAMP_W-1:0]     deadline_q [NUM_FLOWS];
    logic [ACK_W-1:0]           last_ack_q [NUM_FLOWS];
    logic [DUP_ACK_CNT_W-1:0]   dup_cnt_q  [NUM_FLOWS];
    logic [NUM_FLOWS-1:0]       armed_q, fast_q, fast_set;
    logic [TIMESTAMP_W-1:0]     age;
    logic                       arm_ok, dis_ok, ack_ok;
    logic                       arm_hit, dis_hit, cur_expired;
    logic                       load_fast, load_to;

    // Out-of-range ids are dropped; a same-flow arm overrides a disarm.
    assign arm_ok  = arm_val && (32'(arm_flowid) < NUM_FLOWS);
    assign dis_ok  = disarm_val && (32'(disarm_flowid) < NUM_FLOWS)
                     && !(arm_ok && (disarm_flowid == arm_flowid));
    assign ack_ok  = ack_val && (32'(ack_flowid) < NUM_FLOWS);
    assign arm_hit = arm_ok && (arm_flowid == ptr_q);
    assign dis_hit = dis_ok && (disarm_flowid == ptr_q);

    // Wrap-safe expiry: elapsed time since the deadline is non-negative.
    assign age         = now_q - deadline_q[ptr_q];
    assign cur_expired = armed_q[ptr_q] && !age[TIMESTAMP_W-1];
    assign ptr_inc     = (32'(ptr_q) == NUM_FLOWS - 1) ? '0 : ptr_q + FLOWID_W'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        load_fast = 1'b0;
        load_to   = 1'b0;
        unique case (state_q)
            ST_SCAN: begin
                if (fast_q[ptr_q] && !dis_hit) begin
                    load_fast = 1'b1;
                    state_d   = ST_HOLD;
                end else if (cur_expired && !arm_hit && !dis_hit) begin
                    load_to = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    ptr_d = ptr_inc;
                end
            end
            ST_HOLD: begin
                if (evt_rdy) begin
                    state_d = ST_SCAN;
                    ptr_d   = ptr_inc;
                end
            end
        endcase
    end

    // Fast-retransmit fires on the increment that lands exactly on the threshold.
    always_comb begin
        fast_set = '0;
        for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
            fast_set[f] = ack_ok && (32'(ack_flowid) == f)
                          && (ack_num == last_ack_q[f])
                          && (dup_cnt_q[f] != '1)
                          && ((32'(dup_cnt_q[f]) + 32'd1) == DUP_ACK_THRESH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SCAN;
            ptr_q      <= '0;
            now_q      <= NOW_RST_VAL;
            evt_val    <= 1'b0;
            evt_flowid <= '0;
            evt_type   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            now_q   <= now_q + TIMESTAMP_W'(1);
            if (load_fast || load_to) begin
                evt_val    <= 1'b1;
                evt_flowid <= ptr_q;
                evt_type   <= load_fast ? RT_EVT_FAST : RT_EVT_TIMEOUT;
            end else if ((state_q == ST_HOLD) && evt_rdy) begin
                evt_val <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= '0;
            fast_q  <= '0;
            for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
                deadline_q[f] <= '0;
                last_ack_q[f] <= '0;
                dup_cnt_q[f]  <= '0;
            end
        end else begin
            for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
                if (arm_ok && (32'(arm_flowid) == f)) begin
                    deadline_q[f] <= now_q + TIMESTAMP_W'(TIMEOUT_CYCLES);
                    armed_q[f]    <= 1'b1;
                end else if ((dis_ok && (32'(disarm_flowid) == f))
                             || (load_to && (32'(ptr_q) == f))) begin
                    armed_q[f] <= 1'b0;
                end

                // A fresh threshold crossing wins over a same-cycle clear.
                if (fast_set[f]) begin
                    fast_q[f] <= 1'b1;
                end else if ((dis_ok && (32'(disarm_flowid) == f))
                             || (load_fast && (32'(ptr_q) == f))) begin
                    fast_q[f] <= 1'b0;
                end

                if (ack_ok && (32'(ack_flowid) == f)) begin
                    if (ack_num == last_ack_q[f]) begin
                        if (dup_cnt_q[f] != '1) begin
                            dup_cnt_q[f] <= dup_cnt_q[f] + DUP_ACK_CNT_W'(1);
                        end
                    end else begin
                        last_ack_q[f] <= ack_num;
                        dup_cnt_q[f]  <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tcp_rt_event_table.sv
// Bench for tcp_rt_event_table: directed scenarios plus random traffic,
// checked every cycle against a cycle-count based behavioural model.
module tb_tcp_rt_event_table;
    import tcp_pkg::*;

    localparam int unsigned NF   = 4;
    localparam int unsigned FW   = 2;
    localparam int unsigned TO   = 100;
    localparam int unsigned AW   = ACK_NUM_W;
    localparam int unsigned DMAX = (1 << DUP_ACK_CNT_W) - 1;
    localparam logic [TIMESTAMP_W-1:0] NOW0 = 64'hFFFF_FFFF_FFFF_FFCE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm_val = 1'b0, disarm_val = 1'b0, ack_val = 1'b0;
    logic [FW-1:0] arm_flowid = '0, disarm_flowid = '0, ack_flowid = '0;
    logic [AW-1:0] ack_num = '0;
    logic          evt_rdy = 1'b1;
    logic          evt_val;
    logic [FW-1:0] evt_flowid;
    logic          evt_type;

    int   total = 0, bad = 0;
    int   rises = 0, fast_rises = 0;
    logic prev_val = 1'b0;
    int   hs_q[$];

    // Model: deadlines kept as absolute cycle numbers since reset (no wrap).
    longint unsigned m_cyc;
    longint unsigned m_dl [NF];
    bit              m_armed [NF];
    bit              m_fast [NF];
    logic [AW-1:0]   m_last [NF];
    int              m_dup [NF];
    bit              m_hold;
    int              m_ptr, m_fid;
    bit              m_type;

    always #5 clk = ~clk;

    tcp_rt_event_table #(
        .NUM_FLOWS(NF), .FLOWID_W(FW), .TIMEOUT_CYCLES(TO),
        .DUP_ACK_THRESH(3), .ACK_W(AW), .NOW_RST_VAL(NOW0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .arm_val(arm_val), .arm_flowid(arm_flowid),
        .disarm_val(disarm_val), .disarm_flowid(disarm_flowid),
        .ack_val(ack_val), .ack_flowid(ack_flowid), .ack_num(ack_num),
        .evt_val(evt_val), .evt_flowid(evt_flowid), .evt_type(evt_type),
        .evt_rdy(evt_rdy)
    );

    task automatic chk(input string nm, input longint unsigned got, input longint unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input longint got, input longint lo, input longint hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s got=%0d exp=[%0d..%0d]", nm, got, lo, hi);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_hold = 0; m_ptr = 0; m_fid = 0; m_type = 0;
        for (int f = 0; f < NF; f++) begin
            m_dl[f] = 0; m_armed[f] = 0; m_fast[f] = 0; m_last[f] = '0; m_dup[f] = 0;
        end
    endtask

    task automatic model_tick();
        int p;
        bit ld_f, ld_t, dis_eff, arm_hit, dis_hit, setf;
        if (!rst_n) begin
            model_reset();
            return;
        end
        p = m_ptr; ld_f = 0; ld_t = 0;
        dis_eff = disarm_val && !(arm_val && arm_flowid == disarm_flowid);
        arm_hit = arm_val && int'(arm_flowid) == p;
        dis_hit = dis_eff && int'(disarm_flowid) == p;
        if (!m_hold) begin
            if (m_fast[p] && !dis_hit) ld_f = 1;
            else if (m_armed[p] && m_cyc >= m_dl[p] && !arm_hit && !dis_hit) ld_t = 1;
            if (ld_f || ld_t) begin
                m_hold = 1; m_fid = p; m_type = ld_f;
            end else begin
                m_ptr = (p + 1) % NF;
            end
        end else if (evt_rdy) begin
            m_hold = 0;
            m_ptr = (p + 1) % NF;
        end
        for (int f = 0; f < NF; f++) begin
            if (arm_val && int'(arm_flowid) == f) begin
                m_dl[f] = m_cyc + TO;
                m_armed[f] = 1;
            end else if ((dis_eff && int'(disarm_flowid) == f) || (ld_t && p == f)) begin
                m_armed[f] = 0;
            end
            setf = 0;
            if (ack_val && int'(ack_flowid) == f) begin
                if (ack_num == m_last[f]) begin
                    if (m_dup[f] < DMAX) begin
                        m_dup[f]++;
                        if (m_dup[f] == 3) setf = 1;
                    end
                end else begin
                    m_last[f] = ack_num;
                    m_dup[f] = 0;
                end
            end
            if (setf) m_fast[f] = 1;
            else if ((dis_eff && int'(disarm_flowid) == f) || (ld_f && p == f)) m_fast[f] = 0;
        end
        m_cyc++;
    endtask

    // One clock: model and handshake log advance on the edge, pulses clear after.
    task automatic step();
        @(posedge clk);
        if (rst_n && evt_val && evt_rdy) hs_q.push_back(int'(evt_flowid));
        model_tick();
        #1;
        arm_val = 0; disarm_val = 0; ack_val = 0;
        if (evt_val && !prev_val) begin
            rises++;
            if (evt_type) fast_rises++;
        end
        prev_val = evt_val;
    endtask

    task automatic wait_rise(input int bound, output int k);
        int r0;
        r0 = rises;
        k = -1;
        for (int i = 1; i <= bound; i++) begin
            step();
            if (rises != r0) begin
                k = i;
                break;
            end
        end
    endtask

    function automatic bit to_load_pending(input int f);
        return !m_hold && m_ptr == f && m_armed[f] && m_cyc >= m_dl[f] && !m_fast[f];
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_evt_val", evt_val, m_hold);
            if (m_hold) begin
                chk("cyc_evt_flowid", evt_flowid, m_fid);
                chk("cyc_evt_type", evt_type, m_type);
            end
        end
    end

    initial begin
        int k, r0, f0, moved;
        bit found;
        logic [AW-1:0] acks [9];
        acks = '{500, 500, 500, 500, 500, 600, 600, 600, 600};
        model_reset();
        repeat (3) step();
        chk("rst_evt_val", evt_val, 0);
        chk("rst_evt_flowid", evt_flowid, 0);
        chk("rst_evt_type", evt_type, 0);
        rst_n = 1;

        // Single timeout, deadline straddling the timestamp wrap.
        repeat (10) step();
        arm_val = 1; arm_flowid = 2; step();
        wait_rise(120, k);
        chk_rng("t1_latency", k, 100, 103);
        chk("t1_flowid", evt_flowid, 2);
        chk("t1_type", evt_type, 0);
        r0 = rises;
        repeat (200) step();
        chk("t1_no_more", rises - r0, 0);

        // Keep-alive re-arms suppress the timeout until they stop.
        r0 = rises;
        for (int i = 0; i < 20; i++) begin
            arm_val = 1; arm_flowid = 1; step();
            if (i < 19) repeat (49) step();
        end
        chk("t2_quiet", rises - r0, 0);
        wait_rise(150, k);
        chk_rng("t2_latency", k, 100, 103);
        chk("t2_flowid", evt_flowid, 1);
        chk("t2_type", evt_type, 0);
        repeat (10) step();

        // Duplicate ACK runs on flow 0.
        r0 = rises; f0 = fast_rises;
        for (int i = 0; i < 9; i++) begin
            ack_val = 1; ack_flowid = 0; ack_num = acks[i]; step();
            repeat (5) step();
            if (i == 3) chk("t3_first_fast", fast_rises - f0, 1);
            if (i == 4) chk("t3_no_extra", fast_rises - f0, 1);
        end
        repeat (10) step();
        chk("t3_fast_total", fast_rises - f0, 2);
        chk("t3_all_fast", rises - r0, 2);

        // Backpressure: held event stays put, then drains in order.
        evt_rdy = 0;
        for (int f = 0; f < NF; f++) begin
            arm_val = 1; arm_flowid = FW'(f); step();
        end
        wait_rise(150, k);
        chk_rng("t4_rise_seen", k, 90, 110);
        chk("t4_first_flowid", evt_flowid, 0);
        moved = 0;
        repeat (300) begin
            step();
            if (!evt_val || evt_flowid != 0) moved++;
        end
        chk("t4_held_stable", moved, 0);
        hs_q.delete();
        evt_rdy = 1;
        repeat (30) step();
        chk("t4_hs_cnt", hs_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < hs_q.size()) chk("t4_order", hs_q[i], i);

        // Arm collides with the timeout load cycle.
        arm_val = 1; arm_flowid = 3; step();
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (to_load_pending(3)) begin
                found = 1;
                arm_val = 1; arm_flowid = 3; step();
                break;
            end
            step();
        end
        chk("t5_arm_hit_found", found, 1);
        r0 = rises;
        repeat (95) step();
        chk("t5_arm_suppress", rises - r0, 0);
        wait_rise(20, k);
        chk_rng("t5_rearm_latency", k, 5, 8);
        chk("t5_rearm_flowid", evt_flowid, 3);
        repeat (5) step();

        // Disarm collides with the timeout load cycle.
        arm_val = 1; arm_flowid = 3; step();
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (to_load_pending(3)) begin
                found = 1;
                disarm_val = 1; disarm_flowid = 3; step();
                break;
            end
            step();
        end
        chk("t5_dis_hit_found", found, 1);
        r0 = rises;
        repeat (300) step();
        chk("t5_dis_suppress", rises - r0, 0);

        // Reset while an event is held.
        evt_rdy = 0;
        arm_val = 1; arm_flowid = 1; step();
        wait_rise(150, k);
        chk_rng("t6_rise_seen", k, 100, 103);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("t6_rst_drop", evt_val, 0);
        chk("t6_rst_flowid", evt_flowid, 0);
        repeat (3) step();
        rst_n = 1;
        evt_rdy = 1;
        r0 = rises;
        repeat (300) step();
        chk("t6_idle", rises - r0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            evt_rdy = ($urandom_range(3) != 0);
            if ($urandom_range(19) == 0) begin
                arm_val = 1; arm_flowid = FW'($urandom_range(NF - 1));
            end
            if ($urandom_range(29) == 0) begin
                disarm_flowid = FW'($urandom_range(NF - 1));
                disarm_val = !(arm_val && arm_flowid == disarm_flowid);
            end
            if ($urandom_range(3) == 0) begin
                ack_val = 1;
                ack_flowid = FW'($urandom_range(NF - 1));
                ack_num = AW'($urandom_range(2));
            end
            step();
        end
        evt_rdy = 1;
        repeat (50) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
